snake_dir_queue: RTL and testbench
==================================

// Module: snake_dir_queue
// PURPOSE
//  Turn-command buffer between the key inputs (KEY buttons / PS2 keyboard_tracker levels) and the snake
//  datapath. Detects key presses, rejects reversals and no-op turns, queues up to DEPTH turns, and
//  releases one turn per game step tick. Replaces the level-latching direction logic feeding datapath.
// PARAMETERS
//  DEPTH  4  turn FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1   system clock (CLOCK_50 domain)
//  reset_n    in   1   asynchronous active-low reset
//  clear      in   1   sync flush (driven by menu state); same effect as reset except edge regs
//  key_up     in   1   level, active-high (KEY[2]|w already merged, polarity-corrected upstream)
//  key_left   in   1   level, active-high
//  key_down   in   1   level, active-high
//  key_right  in   1   level, active-high
//  tick       in   1   one-cycle pulse, snake advances one cell (datapath step strobe)
//  direction  out  5   one-hot: 00010 up, 00100 left, 01000 down, 10000 right, 00000 idle
//  q_count    out  $clog2(DEPTH+1)  turns currently queued
//  dropped    out  1   one-cycle pulse: accepted-press discarded because queue full
// BEHAVIOUR
//  Reset (async, reset_n=0): direction=00000, q_count=0, dropped=0, FIFO ptrs=0, key_prev regs=1
//   (a key held through reset release produces no press).
//  Internal code: 2-bit, 0=up 1=left 2=down 3=right; reverse(c)=c^2'b10; one-hot = 5'b00010<<c.
//  Press: rising edge of key level (key & ~key_prev), key_prev registered every cycle incl. during clear.
//  Simultaneous presses same cycle: only one taken, priority up > left > down > right.
//  Reference dir R = newest queued entry if q_count>0, else current direction (idle if 00000).
//  Accept press c iff R idle, or (c != R and c != reverse(R)); otherwise ignored silently (no dropped).
//  Accepted press, queue not full -> push; queue full and no pop this cycle -> discard, dropped=1 next cycle.
//  tick with q_count>0: pop head into direction (registered, visible cycle after tick); q_count-1.
//  tick and accepted push same cycle, q_count>0: both occur, q_count unchanged; full+tick permits push.
//  tick and accepted push same cycle, q_count==0: bypass, direction<=c, q_count stays 0.
//  tick with empty queue, no press: direction holds (snake keeps moving / stays idle).
//  Press with no tick: never alters direction directly; only queue.
//  clear=1: FIFO emptied, q_count=0, direction=00000, dropped=0; presses in that cycle discarded.
//   clear has priority over tick and push. reset_n overrides all.
//  Pointers log2(DEPTH) bits, wrap modulo DEPTH; q_count saturates never (full check precedes push).
//  Latency: press at cycle n -> q_count updated n+1; tick at m -> direction updated m+1.
// STRUCTURE
//  snake_pkg: DIR_UP/LEFT/DOWN/RIGHT 2-bit codes, DIR_IDLE_OH=5'b00000, one-hot constants,
//   function dir_to_onehot(code), function dir_reverse(code).
//  Sub-module key_edge_detect (4-bit vector, async reset to 1s) -> press pulses.
//  Top: priority encoder, accept check, FIFO (reg array + rd/wr ptr + count), direction register.
// TESTING
//  1 Reset, press right, tick -> direction=10000 cycle after tick, q_count 1->0; dropped never high.
//  2 From right: press left, tick -> ignored, direction stays 10000; press up,left,down seq -> q 3 (up,left,down).
//  3 From right: press up, left (q=2), no tick -> 3 ticks give 00010, 00100, then holds 00100.
//  4 Fill DEPTH=4 (up,left,down,right alternation valid), 5th valid press -> dropped=1 one cycle, q_count=4;
//    same press coincident with tick -> accepted, q_count stays 4, no dropped.
//  5 Empty queue, press down + tick same cycle from idle -> direction=01000 next cycle, q_count=0.
//  6 Hold key_up across reset release -> no press; clear mid-queue (q=3) -> q_count=0, direction=00000;
//    reset_n low mid-tick -> all outputs 0 immediately.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared direction codes and helpers for the snake turn buffer.
// Internal code is 2 bits; the datapath consumes a 5-bit one-hot.
package snake_pkg;

  typedef logic [1:0] dir_code_t;

  localparam dir_code_t DIR_UP    = 2'd0;
  localparam dir_code_t DIR_LEFT  = 2'd1;
  localparam dir_code_t DIR_DOWN  = 2'd2;
  localparam dir_code_t DIR_RIGHT = 2'd3;

  localparam logic [4:0] DIR_IDLE_OH  = 5'b00000;
  localparam logic [4:0] DIR_UP_OH    = 5'b00010;
  localparam logic [4:0] DIR_LEFT_OH  = 5'b00100;
  localparam logic [4:0] DIR_DOWN_OH  = 5'b01000;
  localparam logic [4:0] DIR_RIGHT_OH = 5'b10000;

  function automatic logic [4:0] dir_to_onehot(input dir_code_t code);
    return 5'b00010 << code;
  endfunction

  // Opposite direction differs only in the upper code bit
  function automatic dir_code_t dir_reverse(input dir_code_t code);
    return code ^ 2'b10;
  endfunction

  function automatic dir_code_t onehot_to_dir(input logic [4:0] oh);
    case (oh)
      DIR_LEFT_OH:  return DIR_LEFT;
      DIR_DOWN_OH:  return DIR_DOWN;
      DIR_RIGHT_OH: return DIR_RIGHT;
      default:      return DIR_UP;
    endcase
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for the four key levels. Previous-state registers reset
// to 1 so a key held through reset release does not register as a press.
module key_edge_detect (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] keys,
  output logic [3:0] press
);

  logic [3:0] key_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) key_prev <= 4'hF;
    else          key_prev <= keys;
  end

  assign press = keys & ~key_prev;

endmodule

// File: rtl/snake_dir_queue.sv
// Turn-command buffer: filters key presses into legal turns, queues them and
// releases one per game step tick into the registered one-hot direction.
module snake_dir_queue
  import snake_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       key_up,
  input  logic                       key_left,
  input  logic                       key_down,
  input  logic                       key_right,
  input  logic                       tick,
  output logic [4:0]                 direction,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic                       dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0]    press;
  logic          press_valid;
  dir_code_t     press_code;
  dir_code_t     fifo [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  dir_code_t     ref_code;
  logic          ref_idle;
  logic          accept;
  logic          full;
  logic          pop;
  logic          bypass;
  logic          push;
  logic          drop;

  key_edge_detect u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .keys    ({key_right, key_down, key_left, key_up}),
    .press   (press)
  );

  always_comb begin
    press_valid = |press;
    press_code  = DIR_UP;
    if      (press[0]) press_code = DIR_UP;
    else if (press[1]) press_code = DIR_LEFT;
    else if (press[2]) press_code = DIR_DOWN;
    else if (press[3]) press_code = DIR_RIGHT;
  end

  // New turns are judged against the last turn that will be in effect before them
  always_comb begin
    ref_code = (q_count != '0) ? fifo[wr_ptr - PW'(1)] : onehot_to_dir(direction);
    ref_idle = (q_count == '0) && (direction == DIR_IDLE_OH);
    accept   = press_valid && !clear &&
               (ref_idle || ((press_code != ref_code) && (press_code != dir_reverse(ref_code))));
    full     = (q_count == CW'(DEPTH));
    pop      = tick && !clear && (q_count != '0);
    bypass   = tick && accept && (q_count == '0);
    push     = accept && !bypass && (!full || pop);
    drop     = accept && !bypass && full && !pop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      direction <= DIR_IDLE_OH;
      q_count   <= '0;
      dropped   <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else if (clear) begin
      direction <= DIR_IDLE_OH;
      q_count   <= '0;
      dropped   <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      dropped <= drop;
      if (pop) begin
        direction <= dir_to_onehot(fifo[rd_ptr]);
        rd_ptr    <= rd_ptr + PW'(1);
      end
      if (bypass) direction <= dir_to_onehot(press_code);
      if (push)   wr_ptr    <= wr_ptr + PW'(1);
      if (push && !pop)      q_count <= q_count + CW'(1);
      else if (pop && !push) q_count <= q_count - CW'(1);
    end
  end

  // Storage needs no reset; only slots behind the pointers are ever read
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= press_code;
  end

endmodule

// File: tb/tb_snake_dir_queue.sv
// Scoreboard bench for snake_dir_queue: directed vectors push hand-computed
// expectations, a monitor compares them one cycle-edge later.
module tb_snake_dir_queue;

  typedef struct packed {
    int         id;
    logic [4:0] dir;
    logic [2:0] q;
    logic       drop;
  } exp_t;

  localparam logic [3:0] K_NONE  = 4'b0000;
  localparam logic [3:0] K_UP    = 4'b0001;
  localparam logic [3:0] K_LEFT  = 4'b0010;
  localparam logic [3:0] K_DOWN  = 4'b0100;
  localparam logic [3:0] K_RIGHT = 4'b1000;

  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_UP    = 5'b00010;
  localparam logic [4:0] O_LEFT  = 5'b00100;
  localparam logic [4:0] O_DOWN  = 5'b01000;
  localparam logic [4:0] O_RIGHT = 5'b10000;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic [3:0] keys;
  logic       tick;
  logic [4:0] direction;
  logic [2:0] q_count;
  logic       dropped;

  exp_t sb[$];
  int   tests_run;
  int   tests_failed;
  int   vec_id;

  snake_dir_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .key_up    (keys[0]),
    .key_left  (keys[1]),
    .key_down  (keys[2]),
    .key_right (keys[3]),
    .tick      (tick),
    .direction (direction),
    .q_count   (q_count),
    .dropped   (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input int id, input logic [4:0] ed, input logic [2:0] eq, input logic edrop);
    tests_run++;
    if (direction !== ed || q_count !== eq || dropped !== edrop) begin
      tests_failed++;
      $display("[TB] FAIL vec%0d: got dir=%b q=%0d drop=%b, expected dir=%b q=%0d drop=%b",
               id, direction, q_count, dropped, ed, eq, edrop);
    end
  endtask

  // One cycle of stimulus; the expectation describes outputs after the next edge
  task automatic applyStimulus(input logic [3:0] k, input logic t, input logic c,
                               input logic [4:0] ed, input logic [2:0] eq, input logic edrop);
    exp_t e;
    @(negedge clk);
    keys  = k;
    tick  = t;
    clear = c;
    @(posedge clk);
    e.id   = vec_id;
    e.dir  = ed;
    e.q    = eq;
    e.drop = edrop;
    sb.push_back(e);
    vec_id++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e.id, e.dir, e.q, e.drop);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    tests_run    = 0;
    tests_failed = 0;
    vec_id       = 0;
    reset_n      = 1'b0;
    clear        = 1'b0;
    keys         = K_NONE;
    tick         = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput(900, O_IDLE, 3'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single turn from idle, then released by a tick
    applyStimulus(K_RIGHT, 1'b0, 1'b0, O_IDLE,  3'd1, 1'b0);
    applyStimulus(K_NONE,  1'b1, 1'b0, O_RIGHT, 3'd0, 1'b0);

    // Reversal ignored; tick on empty queue holds
    applyStimulus(K_LEFT,  1'b0, 1'b0, O_RIGHT, 3'd0, 1'b0);
    applyStimulus(K_NONE,  1'b1, 1'b0, O_RIGHT, 3'd0, 1'b0);
    applyStimulus(K_UP,    1'b0, 1'b0, O_RIGHT, 3'd1, 1'b0);
    applyStimulus(K_NONE,  1'b0, 1'b0, O_RIGHT, 3'd1, 1'b0);
    applyStimulus(K_LEFT,  1'b0, 1'b0, O_RIGHT, 3'd2, 1'b0);
    applyStimulus(K_NONE,  1'b0, 1'b0, O_RIGHT, 3'd2, 1'b0);
    applyStimulus(K_DOWN,  1'b0, 1'b0, O_RIGHT, 3'd3, 1'b0);
    applyStimulus(K_NONE,  1'b0, 1'b0, O_RIGHT, 3'd3, 1'b0);

    // Drain in order, then hold
    applyStimulus(K_NONE,  1'b1, 1'b0, O_UP,    3'd2, 1'b0);
    applyStimulus(K_NONE,  1'b1, 1'b0, O_LEFT,  3'd1, 1'b0);
    applyStimulus(K_NONE,  1'b1, 1'b0, O_DOWN,  3'd0, 1'b0);
    applyStimulus(K_NONE,  1'b1, 1'b0, O_DOWN,  3'd0, 1'b0);

    // Fill to DEPTH, overflow drop, then full+tick push
    applyStimulus(K_RIGHT, 1'b0, 1'b0, O_DOWN,  3'd1, 1'b0);
    applyStimulus(K_NONE,  1'b0, 1'b0, O_DOWN,  3'd1, 1'b0);
    applyStimulus(K_UP,    1'b0, 1'b0, O_DOWN,  3'd2, 1'b0);
    applyStimulus(K_NONE,  1'b0, 1'b0, O_DOWN,  3'd2, 1'b0);
    applyStimulus(K_LEFT,  1'b0, 1'b0, O_DOWN,  3'd3, 1'b0);
    applyStimulus(K_NONE,  1'b0, 1'b0, O_DOWN,  3'd3, 1'b0);
    applyStimulus(K_DOWN,  1'b0, 1'b0, O_DOWN,  3'd4, 1'b0);
    applyStimulus(K_NONE,  1'b0, 1'b0, O_DOWN,  3'd4, 1'b0);
    applyStimulus(K_RIGHT, 1'b0, 1'b0, O_DOWN,  3'd4, 1'b1);
    applyStimulus(K_NONE,  1'b0, 1'b0, O_DOWN,  3'd4, 1'b0);
    applyStimulus(K_RIGHT, 1'b1, 1'b0, O_RIGHT, 3'd4, 1'b0);
    applyStimulus(K_NONE,  1'b0, 1'b0, O_RIGHT, 3'd4, 1'b0);

    // Reversal and no-op against newest entry (right) while full: no drop
    applyStimulus(K_LEFT,  1'b0, 1'b0, O_RIGHT, 3'd4, 1'b0);
    applyStimulus(K_RIGHT, 1'b0, 1'b0, O_RIGHT, 3'd4, 1'b0);
    applyStimulus(K_NONE,  1'b0, 1'b0, O_RIGHT, 3'd4, 1'b0);

    // Pop to q=3, then clear with a coincident press
    applyStimulus(K_NONE,  1'b1, 1'b0, O_UP,    3'd3, 1'b0);
    applyStimulus(K_UP,    1'b0, 1'b1, O_IDLE,  3'd0, 1'b0);
    applyStimulus(K_NONE,  1'b0, 1'b0, O_IDLE,  3'd0, 1'b0);

    // Bypass from idle
    applyStimulus(K_DOWN,  1'b1, 1'b0, O_DOWN,  3'd0, 1'b0);
    applyStimulus(K_NONE,  1'b0, 1'b0, O_DOWN,  3'd0, 1'b0);

    // Simultaneous presses: up wins (a reversal, so ignored); left beats right
    applyStimulus(K_UP | K_RIGHT,   1'b0, 1'b0, O_DOWN, 3'd0, 1'b0);
    applyStimulus(K_NONE,           1'b0, 1'b0, O_DOWN, 3'd0, 1'b0);
    applyStimulus(K_LEFT | K_RIGHT, 1'b0, 1'b0, O_DOWN, 3'd1, 1'b0);
    applyStimulus(K_NONE,           1'b1, 1'b0, O_LEFT, 3'd0, 1'b0);

    // Async reset mid-cycle with tick and key_up asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    keys = K_UP;
    tick = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput(901, O_IDLE, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick    = 1'b0;

    // Key held through reset release is not a press
    applyStimulus(K_UP,    1'b0, 1'b0, O_IDLE,  3'd0, 1'b0);
    applyStimulus(K_NONE,  1'b0, 1'b0, O_IDLE,  3'd0, 1'b0);
    applyStimulus(K_UP,    1'b0, 1'b0, O_IDLE,  3'd1, 1'b0);
    applyStimulus(K_NONE,  1'b1, 1'b0, O_UP,    3'd0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
